// File: rtl/mips_pkg.sv
// mips_pkg: shared word width, byte-offset width and default memory depth.
package mips_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_OFFSET_W = 2;
  localparam int MEM_DEPTH_WORDS = 1024;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/mips_memory_mem_index.sv
// mem_index: byte address to word index; offset and high bits drop out, so addresses wrap.
module mem_index
  import mips_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic [WORD_W-1:0] addr,
  output logic [AW-1:0]     idx
);
  logic unused_bits;
  assign unused_bits = ^{addr[WORD_W-1:AW+BYTE_OFFSET_W], addr[BYTE_OFFSET_W-1:0]};
  assign idx = addr[AW+BYTE_OFFSET_W-1:BYTE_OFFSET_W];
endmodule

// File: rtl/mips_memory.sv
// mips_memory: unified word RAM, combinational fetch and load ports, synchronous store.
module mips_memory
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = MEM_DEPTH_WORDS,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PC,
  output logic [31:0] instruction,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  input  logic        wr_en,
  output logic [31:0] data_out
);
  word_t mem [DEPTH_WORDS];
  logic [AW-1:0] pc_idx, d_idx;
  mem_index #(.AW(AW)) u_pc_idx (.addr(PC), .idx(pc_idx));
  mem_index #(.AW(AW)) u_d_idx (.addr(data_addr), .idx(d_idx));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    else if (wr_en)
      mem[d_idx] <= data_in;
  assign instruction = mem[pc_idx];
  assign data_out = mem[d_idx];
endmodule

// File: tb/tb_mips_memory.sv
// tb_mips_memory: randomized scoreboard bench against a flat word-array reference model.
module tb_mips_memory;
  localparam int DEPTH = 1024;
  logic clk = 0, rst_n = 0, wr_en = 0;
  logic [31:0] PC = 0, data_addr = 0, data_in = 0, instruction, data_out;
  int checks = 0, failures = 0;
  logic [31:0] model [DEPTH];
  typedef struct {
    logic [31:0] ei;
    logic [31:0] ed;
    string nm;
  } exp_t;
  exp_t q[$];
  event ev;

  mips_memory dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .instruction(instruction),
    .data_addr(data_addr), .data_in(data_in), .wr_en(wr_en), .data_out(data_out)
  );

  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
  endtask

  task automatic expect_now(input string nm);
    exp_t e;
    e.ei = model[widx(PC)];
    e.ed = model[widx(data_addr)];
    e.nm = nm;
    q.push_back(e);
    ->ev;
  endtask

  task automatic step(input logic [31:0] pc, input logic [31:0] da, input logic [31:0] di,
                      input logic we, input string nm);
    @(negedge clk);
    PC = pc; data_addr = da; data_in = di; wr_en = we;
    #1 expect_now(nm);
    if (we && rst_n) model[widx(da)] = di;
  endtask

  initial begin
    forever begin
      @(ev);
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (instruction !== e.ei) begin
          failures++;
          $display("FAIL %s instruction: got %h expected %h", e.nm, instruction, e.ei);
        end
        checks++;
        if (data_out !== e.ed) begin
          failures++;
          $display("FAIL %s data_out: got %h expected %h", e.nm, data_out, e.ed);
        end
      end
    end
  end

  initial begin
    logic [31:0] pc, da;
    clear_model();
    #1;
    step(32'h8, 32'h8, 32'hFFFF_FFFF, 1, "reset_write");
    step(32'h8, 32'h8, 32'hFFFF_FFFF, 1, "reset_hold");
    @(negedge clk); rst_n = 1; wr_en = 0;
    step(32'h8, 32'h8, 32'h0, 0, "after_release");
    step(32'h0, 32'h8, 32'h1, 1, "write_1");
    step(32'h8, 32'h8, 32'h0, 0, "fetch_1");
    step(32'h8, 32'h8, 32'h0, 0, "fetch_1_unchanged");
    step(32'h0, 32'hC, 32'h4, 1, "write_4");
    step(32'hC, 32'h4, 32'h0, 0, "independent");
    step(32'h0, 32'hE, 32'hDEAD_BEEF, 1, "write_unaligned");
    step(32'hC, 32'hF, 32'h0, 0, "alias_unaligned");
    step(32'h0, 32'h1000, 32'h1234_5678, 1, "write_wrap");
    step(32'h0, 32'h8, 32'h0, 0, "wrap_fetch");
    step(32'hFFFF_FFFC, 32'h3FFC, 32'hA5A5_0F0F, 1, "write_top");
    step(32'h0000_0FFC, 32'hFFFF_FFFD, 32'h0, 0, "top_alias");
    step(32'h10, 32'h10, 32'h7777_7777, 0, "no_write");
    step(32'h10, 32'h10, 32'h0, 0, "no_write_check");
    for (int i = 0; i < 400; i++) begin
      pc = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 63);
      da = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 63);
      step(pc, da, $urandom, $urandom_range(0, 1) == 1, "random");
    end
    @(posedge clk);
    #2 rst_n = 0;
    clear_model();
    #1 expect_now("mid_reset");
    step(32'h8, 32'hC, 32'h5555_5555, 1, "mid_reset_hold");
    @(negedge clk); rst_n = 1; wr_en = 0;
    step(32'hC, 32'h8, 32'h0, 0, "post_reset");
    step(32'h0, 32'h20, 32'h9, 1, "post_reset_write");
    step(32'h20, 32'h0, 32'h0, 0, "post_reset_fetch");
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_memory.md
# mips_memory

Unified instruction/data memory for the single-cycle MIPS CPU. It is one word-addressed RAM array with two read ports and one write port. The instruction fetch port is addressed by `PC` and the data load port by `data_addr`; both are combinational. Stores are synchronous on the rising clock edge. The array sits between the datapath's PC register / ALU address output and the instruction decoder / write-back mux.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two.
- `AW`, default `$clog2(DEPTH_WORDS)`: word-index width, derived.

Ports:
- `clk`  in  1  system clock; writes occur on its rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `PC`  in  32  byte address of the instruction to fetch.
- `instruction`  out  32  word at `PC`.
- `data_addr`  in  32  byte address for data load/store.
- `data_in`  in  32  store data.
- `wr_en`  in  1  store enable.
- `data_out`  out  32  word at `data_addr`.

## Operation
- **Word index:** word index = `addr[AW+1:2]`.
  - Bits [1:0] are ignored; unaligned addresses resolve to the containing word.
  - Bits above `AW+1` are ignored, so addresses wrap modulo `DEPTH_WORDS*4` bytes.
- **Single array:** instruction and data share one array. A word stored via `data_addr` is fetchable via `PC` at the same byte address, and the reverse also holds.
- **Reads:** `instruction` = mem[PC index] and `data_out` = mem[data_addr index]. Both are purely combinational and update in the same delta as an address or array change.
- **Write:** on rising `clk`, if `rst_n`=1 and `wr_en`=1, then mem[data_addr index] <= `data_in`. Full 32-bit word only; there are no byte enables.
- **`wr_en`=0:** the array is unchanged regardless of `data_in`.
- **Reset:** `rst_n`=0 asynchronously clears every word to 0.
  - While `rst_n` is low, writes are ignored and both outputs read 0.
  - Reset asserted mid-operation discards all stored contents immediately.
- **Same-port collision:** both read ports may address the word being written. They show the old value before the edge and the new value after it. There is no write-through bypass.
- **X inputs:** `wr_en`=X is not a legal input. The bench never drives it.

## Timing
- Read latency is 0 cycles (combinational) on both ports.
- Write latency is 1 edge. Data is visible on `data_out` and `instruction` after the rising edge that samples `wr_en`=1.
- Inputs must be stable around the rising edge; the bench changes them on the falling edge.
- The outputs under reset are 0, since every word is 0.
- Release of reset is synchronous-safe. The first write accepted is on the first rising edge with `rst_n`=1.

## Structure
- Shared package `mips_pkg` holds:
  - `WORD_W` = 32.
  - `BYTE_OFFSET_W` = 2.
  - Default `MEM_DEPTH_WORDS` = 1024.
  - A `word_t` typedef.
- One natural sub-module: `mem_index`, the combinational byte-address → word-index decoder. It is instantiated twice (PC port and data port), and the write path reuses the data-port index.
- The array itself is written inline with an always block: asynchronous reset clears all words, and the rising-edge write uses the decoded index.

## Test plan
- Reset: hold `rst_n`=0, pulse `wr_en`=1, `data_addr`=0x8, `data_in`=0xFFFF_FFFF → `data_out`=0 and `instruction`=0; after release, mem[0x8] is still 0.
- Write then data read: `data_addr`=0x8, `data_in`=1, `wr_en`=1 for one rising edge → `data_out`=1 one time unit after the edge.
- Fetch of stored word:
  - `PC`=0x8, `wr_en`=0, `data_in`=0, `data_addr`=0x8 → `instruction`=1; the contents are unchanged after the edge.
- Independent address:
  - `data_addr`=0xC, `data_in`=4, `wr_en`=1 → `data_out`=4.
  - Then `PC`=0xC, `data_addr`=0x4, `wr_en`=0 → `instruction`=4 and `data_out`=0.
- Alias/wrap:
  - Write 0xDEAD_BEEF to `data_addr`=0xE (unaligned) → readable at `PC`=0xC.
  - With default depth, write to 0x1000 → readable at `PC`=0x0.
- Mid-run reset: after the above, assert `rst_n`=0 between edges → both outputs go to 0 immediately, without a clock edge.
